// File: rtl/unified_mem_arbiter_if.sv
// ============================================================================
// Module      : unified_mem_arbiter_if
// Description : Bundles the fetch, data and memory-side signals of the unified
//               memory arbiter. The slave modport is the arbiter's view. The
//               master modport is the view of the core plus memory around it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface unified_mem_arbiter_if #(
    parameter int AW = 32
);
    // Instruction-fetch side
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_valid;
    logic [31:0]   if_rdata;

    // Data (load/store) side
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_valid;
    logic [31:0]   d_rdata;

    // Single-ported memory side
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    // Pipeline freeze towards the PC and the register file
    logic          stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_valid, if_rdata, d_valid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_valid, if_rdata, d_valid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, stall
    );
endinterface

`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Shares one single-ported memory between instruction fetch and
//               data accesses. Data has fixed priority over fetch. Each access
//               strobes mem_en for one cycle, waits MEM_LAT cycles and then
//               pulses the granted side's valid. It then returns to IDLE for
//               one bubble cycle before arbitrating again.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module unified_mem_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int AW      = 32
) (
    input  wire logic            clk,
    input  wire logic            reset,
    unified_mem_arbiter_if.slave bus
);

    // Four bits are enough for the largest legal latency of 8.
    localparam int CNT_W = 4;

    // Reject latencies outside 1..8 at elaboration time.
    generate
        if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_bad_mem_lat
            $error("unified_mem_arbiter: MEM_LAT must lie in 1..8");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_D = 2'd1,
        ST_BUSY_I = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mem_en_q;
    logic             mem_we_q;
    logic [AW-1:0]    mem_addr_q;
    logic [31:0]      mem_wdata_q;
    logic             if_valid_q;
    logic             d_valid_q;

    // Arbitration and latency-tracking FSM. All memory-side and valid outputs
    // are registered here. The strobes default low every cycle, so each one
    // lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
        end else begin
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // Data wins any tie with fetch.
                    if (bus.d_req) begin
                        state_q     <= ST_BUSY_D;
                        cnt_q       <= CNT_W'(MEM_LAT);
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= bus.d_we;
                        mem_addr_q  <= bus.d_addr;
                        mem_wdata_q <= bus.d_wdata;
                    end else if (bus.if_req) begin
                        // A fetch leaves mem_wdata at its last value.
                        state_q    <= ST_BUSY_I;
                        cnt_q      <= CNT_W'(MEM_LAT);
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= bus.if_addr;
                    end
                end

                ST_BUSY_D, ST_BUSY_I: begin
                    if (cnt_q == '0) begin
                        // The valid cycle has just been presented.
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        // Raise valid so that it coincides with cnt reaching 0,
                        // which is the cycle the memory returns its data.
                        if (cnt_q == CNT_W'(1)) begin
                            if (state_q == ST_BUSY_D) begin
                                d_valid_q <= 1'b1;
                            end else begin
                                if_valid_q <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.d_valid   = d_valid_q;

    // Read data is a plain passthrough. Consumers qualify it with their valid.
    assign bus.if_rdata = bus.mem_rdata;
    assign bus.d_rdata  = bus.mem_rdata;

    // A side stalls the core while its request is pending and not yet answered.
    assign bus.stall = (bus.if_req & ~if_valid_q) | (bus.d_req & ~d_valid_q);

endmodule

`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
// ============================================================================
// Module      : tb_unified_mem_arbiter
// Description : Scoreboard bench for unified_mem_arbiter. Requesters push the
//               expected outcome of each access. A negedge monitor pops and
//               compares whenever a valid pulse appears. The memory is modelled
//               as a word store that answers reads MEM_LAT cycles after the
//               strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_unified_mem_arbiter;

    localparam int LAT     = 4;
    localparam int AW      = 32;
    localparam int TIMEOUT = 60;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    unified_mem_arbiter_if #(.AW(AW)) bus ();

    unified_mem_arbiter #(.MEM_LAT(LAT), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cycle);
    endtask

    // Initial memory content: an arbitrary function of the address.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hE3A0_0005;
    endfunction

    // ---------------- memory device model ----------------
    logic [31:0] dev_mem [logic [31:0]];
    logic [31:0] pipe [LAT];

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            dev_mem[bus.mem_addr] = bus.mem_wdata;
        end
        if (bus.mem_en && !bus.mem_we) begin
            pipe[0] <= dev_mem.exists(bus.mem_addr) ? dev_mem[bus.mem_addr]
                                                    : init_word(bus.mem_addr);
        end else begin
            pipe[0] <= 32'h0BAD_0BAD;
        end
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mem_rdata = pipe[LAT-1];

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        if_q[$];
    exp_t        d_q[$];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Issue one fetch and hold the request until the fetch valid appears.
    task automatic do_fetch(input logic [31:0] a);
        exp_t e;
        bit   done;
        int   n;
        e.addr = a; e.we = 1'b0; e.wdata = '0; e.rdata = init_word(a);
        if_q.push_back(e);
        bus.if_addr = a;
        bus.if_req  = 1'b1;
        done = 0; n = 0;
        while (!done) begin
            @(posedge clk); #1;
            n++;
            if (bus.if_valid) done = 1;
            else if (n >= TIMEOUT) begin
                fail_now("fetch_timeout");
                done = 1;
            end
        end
        bus.if_req = 1'b0;
    endtask

    // Issue one load or store and hold the request until the data valid.
    task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        bit   done;
        int   n;
        e.addr = a; e.we = we; e.wdata = wd; e.rdata = ref_read(a);
        if (we) ref_mem[a] = wd;
        d_q.push_back(e);
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        bus.d_req   = 1'b1;
        done = 0; n = 0;
        while (!done) begin
            @(posedge clk); #1;
            n++;
            if (bus.d_valid) done = 1;
            else if (n >= TIMEOUT) begin
                fail_now("data_timeout");
                done = 1;
            end
        end
        bus.d_req = 1'b0;
    endtask

    // Wait for the next memory strobe and return the cycle it was seen in.
    task automatic wait_en(output int c);
        int n;
        c = -1; n = 0;
        while (c < 0 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
            if (bus.mem_en) c = cycle;
        end
        if (c < 0) fail_now("mem_en_timeout");
    endtask

    // Monitor: records each strobe and checks every valid pulse against the
    // oldest expectation of that side. It also checks the cycle invariants.
    int          acc_cyc = -1000;
    logic [31:0] acc_addr, acc_wdata;
    logic        acc_we;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_en) begin
                acc_cyc   = cycle;
                acc_addr  = bus.mem_addr;
                acc_we    = bus.mem_we;
                acc_wdata = bus.mem_wdata;
            end
            chk("we_without_en", 32'(bus.mem_we & ~bus.mem_en), 32'd0);
            chk("both_valid", 32'(bus.if_valid & bus.d_valid), 32'd0);
            chk("stall", 32'(bus.stall),
                32'((bus.if_req & ~bus.if_valid) | (bus.d_req & ~bus.d_valid)));
            if (bus.if_valid) begin
                if (if_q.size() == 0) fail_now("unexpected_if_valid");
                else begin
                    exp_t e;
                    e = if_q.pop_front();
                    chk("if_addr", acc_addr, e.addr);
                    chk("if_we", 32'(acc_we), 32'd0);
                    chk("if_rdata", bus.if_rdata, e.rdata);
                    chk("if_latency", 32'(cycle - acc_cyc), 32'(LAT));
                end
            end
            if (bus.d_valid) begin
                if (d_q.size() == 0) fail_now("unexpected_d_valid");
                else begin
                    exp_t e;
                    e = d_q.pop_front();
                    chk("d_addr", acc_addr, e.addr);
                    chk("d_we", 32'(acc_we), 32'(e.we));
                    if (e.we) chk("d_wdata", acc_wdata, e.wdata);
                    else      chk("d_rdata", bus.d_rdata, e.rdata);
                    chk("d_latency", 32'(cycle - acc_cyc), 32'(LAT));
                end
            end
        end
    end

    // Hard stop if anything hangs.
    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int c0, c1, c2, seen;
        int en_c[4];

        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req  = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        // Both requests held through reset; data must go first afterwards,
        // and the fetch must follow exactly LAT+2 cycles later.
        fork
            do_data(1'b0, 32'h1000_0100, 32'h0);
            do_fetch(32'h0000_0040);
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
                chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
                chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
                chk("rst_d_valid", 32'(bus.d_valid), 32'd0);
                chk("rst_mem_addr", bus.mem_addr, 32'h0);
                chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
                reset = 1'b0;
                wait_en(c1);
                chk("first_grant_addr", bus.mem_addr, 32'h1000_0100);
                chk("first_grant_we", 32'(bus.mem_we), 32'd0);
                wait_en(c2);
                chk("second_grant_addr", bus.mem_addr, 32'h0000_0040);
                chk("grant_gap", 32'(c2 - c1), 32'(LAT + 2));
            end
        join
        repeat (3) @(posedge clk); #1;

        // Single fetch from IDLE: strobe in the very next cycle.
        c0 = cycle;
        fork
            do_fetch(32'h0000_0010);
            begin
                wait_en(c1);
                chk("fetch_en_delay", 32'(c1 - c0), 32'd1);
                chk("fetch_addr", bus.mem_addr, 32'h0000_0010);
                chk("fetch_we", 32'(bus.mem_we), 32'd0);
            end
        join
        repeat (2) @(posedge clk); #1;

        // Store, then a fetch (store data must stay on mem_wdata), then load back.
        fork
            do_data(1'b1, 32'h1000_0200, 32'hDEAD_BEEF);
            begin
                wait_en(c1);
                chk("store_we", 32'(bus.mem_we), 32'd1);
                chk("store_addr", bus.mem_addr, 32'h1000_0200);
                chk("store_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            end
        join
        do_fetch(32'h0000_0020);
        chk("wdata_held_by_fetch", bus.mem_wdata, 32'hDEAD_BEEF);
        do_data(1'b0, 32'h1000_0200, 32'h0);
        repeat (2) @(posedge clk); #1;

        // Reset two cycles into a fetch: no valid may follow, and the FSM is idle.
        bus.if_addr = 32'h0000_0080;
        bus.if_req  = 1'b1;
        wait_en(c1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        bus.if_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_mem_en", 32'(bus.mem_en), 32'd0);
        chk("abort_mem_addr", bus.mem_addr, 32'h0);
        seen = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (bus.if_valid) seen++;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        @(posedge clk); #1;
        c0 = cycle;
        fork
            do_fetch(32'h0000_0084);
            begin
                wait_en(c1);
                chk("after_abort_en_delay", 32'(c1 - c0), 32'd1);
            end
        join
        repeat (2) @(posedge clk); #1;

        // Back-to-back fetches: one strobe every LAT+2 cycles, never a write.
        fork
            for (int i = 0; i < 4; i++) do_fetch(32'h0000_0100 + 32'(i * 4));
            for (int i = 0; i < 4; i++) begin
                wait_en(en_c[i]);
                chk("b2b_we", 32'(bus.mem_we), 32'd0);
                if (i > 0) chk("b2b_period", 32'(en_c[i] - en_c[i-1]), 32'(LAT + 2));
            end
        join
        repeat (2) @(posedge clk); #1;

        // Randomised concurrent traffic from both sides.
        fork
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                do_fetch(32'($urandom_range(0, 255)) << 2);
            end
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                do_data(1'($urandom_range(0, 1)),
                        32'h1000_0000 | (32'($urandom_range(0, 15)) << 2),
                        32'($urandom));
            end
        join

        repeat (LAT + 4) @(posedge clk);
        #1;
        chk("if_queue_drained", 32'(if_q.size()), 32'd0);
        chk("d_queue_drained", 32'(d_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
